// File: rtl/depar_pkg.sv
// Shared types and parameter helpers for the deparser segment gatherer.
package depar_pkg;

  // Gatherer phases: fill first half, fill second half, forward the rest.
  typedef enum logic [1:0] {
    COLLECT_FST = 2'd0,
    COLLECT_SND = 2'd1,
    FLUSH       = 2'd2
  } state_e;

  localparam int VLAN_W = 12;

  // Slots per half-bundle.
  function automatic int calc_half(input int num_segs);
    return num_segs / 2;
  endfunction

  // Width of a counter that must reach the value `half` inclusive.
  function automatic int calc_cnt_w(input int half);
    return $clog2(half + 1);
  endfunction

  // Width of a slot index; at least one bit even for a single slot.
  function automatic int calc_idx_w(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/depar_seg_slot_buf.sv
// One half-bundle register bank: C_HALF beat slots with a bulk clear,
// indexed write, a count of slots written since the last clear, and a
// one-cycle valid pulse announcing the bundle.
module depar_seg_slot_buf #(
  parameter int C_DATA_W = 256,
  parameter int C_USER_W = 128,
  parameter int C_KEEP_W = 32,
  parameter int C_HALF   = 2,
  parameter int C_IDX_W  = 1,
  parameter int C_CNT_W  = 2
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         clr_i,
  input  logic                         wr_en_i,
  input  logic [C_IDX_W-1:0]           wr_idx_i,
  input  logic [C_DATA_W-1:0]          wr_tdata_i,
  input  logic [C_USER_W-1:0]          wr_tuser_i,
  input  logic [C_KEEP_W-1:0]          wr_tkeep_i,
  input  logic                         wr_tlast_i,
  input  logic                         emit_i,
  output logic [C_DATA_W*C_HALF-1:0]   tdata_o,
  output logic [C_USER_W*C_HALF-1:0]   tuser_o,
  output logic [C_KEEP_W*C_HALF-1:0]   tkeep_o,
  output logic [C_HALF-1:0]            tlast_o,
  output logic [C_CNT_W-1:0]           nsegs_o,
  output logic                         valid_o
);

  logic [C_DATA_W*C_HALF-1:0] tdata_q;
  logic [C_USER_W*C_HALF-1:0] tuser_q;
  logic [C_KEEP_W*C_HALF-1:0] tkeep_q;
  logic [C_HALF-1:0]          tlast_q;
  logic [C_CNT_W-1:0]         nsegs_q;
  logic                       valid_q;

  // Slot bank: a write to a slot wins over the clear issued in the same cycle.
  // NOTE: this bank drives module outputs directly and must read 0 after reset,
  // so unlike a plain storage array it is reset. Sequential state uses <= only,
  // so every slot sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      tdata_q <= '0;
      tuser_q <= '0;
      tkeep_q <= '0;
      tlast_q <= '0;
      nsegs_q <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < C_HALF; i++) begin
        if (wr_en_i && (wr_idx_i == C_IDX_W'(i))) begin
          tdata_q[i*C_DATA_W +: C_DATA_W] <= wr_tdata_i;
          tuser_q[i*C_USER_W +: C_USER_W] <= wr_tuser_i;
          tkeep_q[i*C_KEEP_W +: C_KEEP_W] <= wr_tkeep_i;
          tlast_q[i]                      <= wr_tlast_i;
        end else if (clr_i) begin
          tdata_q[i*C_DATA_W +: C_DATA_W] <= '0;
          tuser_q[i*C_USER_W +: C_USER_W] <= '0;
          tkeep_q[i*C_KEEP_W +: C_KEEP_W] <= '0;
          tlast_q[i]                      <= 1'b0;
        end
      end
      if (clr_i)
        nsegs_q <= wr_en_i ? C_CNT_W'(1) : '0;
      else if (wr_en_i)
        nsegs_q <= nsegs_q + C_CNT_W'(1);
      valid_q <= emit_i;
    end
  end

  assign tdata_o = tdata_q;
  assign tuser_o = tuser_q;
  assign tkeep_o = tkeep_q;
  assign tlast_o = tlast_q;
  assign nsegs_o = nsegs_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/depar_seg_gather.sv
// Deparser front-end segment gatherer. Pops beats from a FWFT packet FIFO,
// packs the first H beats and the next H beats of each packet into two
// half-bundles, forwards the remaining beats one per cycle, extracts the
// VLAN ID from beat 0 and keeps packet / flushed-beat statistics.
module depar_seg_gather
  import depar_pkg::*;
#(
  parameter int  C_AXIS_DATA_WIDTH  = 256,
  parameter int  C_AXIS_TUSER_WIDTH = 128,
  parameter int  C_NUM_SEGS         = 4,
  parameter int  C_VLAN_OFFSET      = 116,
  localparam int H  = calc_half(C_NUM_SEGS),
  localparam int K  = C_AXIS_DATA_WIDTH / 8,
  localparam int CW = calc_cnt_w(H)
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    pkt_fifo_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   pkt_fifo_tuser,
  input  logic [K-1:0]                    pkt_fifo_tkeep,
  input  logic                            pkt_fifo_tlast,
  input  logic                            pkt_fifo_empty,
  output logic                            pkt_fifo_rd_en,
  input  logic                            fst_half_fifo_ready,
  input  logic                            snd_half_fifo_ready,
  input  logic                            output_fifo_ready,
  output logic [VLAN_W-1:0]               vlan,
  output logic                            vlan_valid,
  output logic [C_AXIS_DATA_WIDTH*H-1:0]  fst_half_tdata,
  output logic [C_AXIS_TUSER_WIDTH*H-1:0] fst_half_tuser,
  output logic [K*H-1:0]                  fst_half_tkeep,
  output logic [H-1:0]                    fst_half_tlast,
  output logic [CW-1:0]                   fst_half_nsegs,
  output logic                            fst_half_valid,
  output logic [C_AXIS_DATA_WIDTH*H-1:0]  snd_half_tdata,
  output logic [C_AXIS_TUSER_WIDTH*H-1:0] snd_half_tuser,
  output logic [K*H-1:0]                  snd_half_tkeep,
  output logic [H-1:0]                    snd_half_tlast,
  output logic [CW-1:0]                   snd_half_nsegs,
  output logic                            snd_half_valid,
  output logic [C_AXIS_DATA_WIDTH-1:0]    output_fifo_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   output_fifo_tuser,
  output logic [K-1:0]                    output_fifo_tkeep,
  output logic                            output_fifo_tlast,
  output logic                            output_fifo_valid,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     flush_count
);

  localparam int IW = calc_idx_w(H);

  state_e                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            last_slot, beat_ok;
  logic                            clr, fst_wr, snd_wr, fst_emit, snd_emit;
  logic                            flush_pop, vlan_ld;
  logic [VLAN_W-1:0]               vlan_q;
  logic                            vlan_valid_q;
  logic [C_AXIS_DATA_WIDTH-1:0]    out_tdata_q;
  logic [C_AXIS_TUSER_WIDTH-1:0]   out_tuser_q;
  logic [K-1:0]                    out_tkeep_q;
  logic                            out_tlast_q, out_valid_q;
  logic [31:0]                     pkt_count_q, flush_count_q;

  assign last_slot = (idx_q == IW'(H - 1));

  // Next-state logic: decide whether the head beat may be popped and where it goes.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    beat_ok        = 1'b1;
    pkt_fifo_rd_en = 1'b0;
    clr            = 1'b0;
    fst_wr         = 1'b0;
    snd_wr         = 1'b0;
    fst_emit       = 1'b0;
    snd_emit       = 1'b0;
    flush_pop      = 1'b0;
    vlan_ld        = 1'b0;
    case (state_q)
      COLLECT_FST: begin
        if (pkt_fifo_tlast)  beat_ok = fst_half_fifo_ready && snd_half_fifo_ready;
        else if (last_slot)  beat_ok = fst_half_fifo_ready;
        if (!pkt_fifo_empty && beat_ok) begin
          pkt_fifo_rd_en = 1'b1;
          fst_wr         = 1'b1;
          if (idx_q == '0) begin
            clr     = 1'b1;
            vlan_ld = 1'b1;
          end
          if (pkt_fifo_tlast) begin
            fst_emit = 1'b1;
            snd_emit = 1'b1;
            idx_d    = '0;
          end else if (last_slot) begin
            fst_emit = 1'b1;
            state_d  = COLLECT_SND;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      COLLECT_SND: begin
        if (pkt_fifo_tlast || last_slot) beat_ok = snd_half_fifo_ready;
        if (!pkt_fifo_empty && beat_ok) begin
          pkt_fifo_rd_en = 1'b1;
          snd_wr         = 1'b1;
          if (pkt_fifo_tlast) begin
            snd_emit = 1'b1;
            state_d  = COLLECT_FST;
            idx_d    = '0;
          end else if (last_slot) begin
            snd_emit = 1'b1;
            state_d  = FLUSH;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      FLUSH: begin
        beat_ok = output_fifo_ready;
        if (!pkt_fifo_empty && beat_ok) begin
          pkt_fifo_rd_en = 1'b1;
          flush_pop      = 1'b1;
          if (pkt_fifo_tlast) state_d = COLLECT_FST;
        end
      end
      default: begin
        state_d = COLLECT_FST;
        idx_d   = '0;
      end
    endcase
  end

  // FSM state, VLAN capture, remainder beat register and statistics.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q       <= COLLECT_FST;
      idx_q         <= '0;
      vlan_q        <= '0;
      vlan_valid_q  <= 1'b0;
      out_tdata_q   <= '0;
      out_tuser_q   <= '0;
      out_tkeep_q   <= '0;
      out_tlast_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      pkt_count_q   <= '0;
      flush_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vlan_valid_q <= vlan_ld;
      if (vlan_ld) vlan_q <= pkt_fifo_tdata[C_VLAN_OFFSET +: VLAN_W];
      out_valid_q <= flush_pop;
      out_tdata_q <= flush_pop ? pkt_fifo_tdata : '0;
      out_tuser_q <= flush_pop ? pkt_fifo_tuser : '0;
      out_tkeep_q <= flush_pop ? pkt_fifo_tkeep : '0;
      out_tlast_q <= flush_pop && pkt_fifo_tlast;
      if (flush_pop) flush_count_q <= flush_count_q + 32'd1;
      if (pkt_fifo_rd_en && pkt_fifo_tlast) pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  depar_seg_slot_buf #(
    .C_DATA_W (C_AXIS_DATA_WIDTH),
    .C_USER_W (C_AXIS_TUSER_WIDTH),
    .C_KEEP_W (K),
    .C_HALF   (H),
    .C_IDX_W  (IW),
    .C_CNT_W  (CW)
  ) u_fst_buf (
    .clk        (clk),
    .aresetn    (aresetn),
    .clr_i      (clr),
    .wr_en_i    (fst_wr),
    .wr_idx_i   (idx_q),
    .wr_tdata_i (pkt_fifo_tdata),
    .wr_tuser_i (pkt_fifo_tuser),
    .wr_tkeep_i (pkt_fifo_tkeep),
    .wr_tlast_i (pkt_fifo_tlast),
    .emit_i     (fst_emit),
    .tdata_o    (fst_half_tdata),
    .tuser_o    (fst_half_tuser),
    .tkeep_o    (fst_half_tkeep),
    .tlast_o    (fst_half_tlast),
    .nsegs_o    (fst_half_nsegs),
    .valid_o    (fst_half_valid)
  );

  depar_seg_slot_buf #(
    .C_DATA_W (C_AXIS_DATA_WIDTH),
    .C_USER_W (C_AXIS_TUSER_WIDTH),
    .C_KEEP_W (K),
    .C_HALF   (H),
    .C_IDX_W  (IW),
    .C_CNT_W  (CW)
  ) u_snd_buf (
    .clk        (clk),
    .aresetn    (aresetn),
    .clr_i      (clr),
    .wr_en_i    (snd_wr),
    .wr_idx_i   (idx_q),
    .wr_tdata_i (pkt_fifo_tdata),
    .wr_tuser_i (pkt_fifo_tuser),
    .wr_tkeep_i (pkt_fifo_tkeep),
    .wr_tlast_i (pkt_fifo_tlast),
    .emit_i     (snd_emit),
    .tdata_o    (snd_half_tdata),
    .tuser_o    (snd_half_tuser),
    .tkeep_o    (snd_half_tkeep),
    .tlast_o    (snd_half_tlast),
    .nsegs_o    (snd_half_nsegs),
    .valid_o    (snd_half_valid)
  );

  assign vlan              = vlan_q;
  assign vlan_valid        = vlan_valid_q;
  assign output_fifo_tdata = out_tdata_q;
  assign output_fifo_tuser = out_tuser_q;
  assign output_fifo_tkeep = out_tkeep_q;
  assign output_fifo_tlast = out_tlast_q;
  assign output_fifo_valid = out_valid_q;
  assign pkt_count         = pkt_count_q;
  assign flush_count       = flush_count_q;

endmodule

// File: tb/tb_depar_seg_gather.sv
// Directed bench for depar_seg_gather: a 4-segment instance (a_*) and an
// 8-segment instance (b_*), driven from the negative clock edge.
module tb_depar_seg_gather;

  localparam int D = 256;
  localparam int U = 128;
  localparam int K = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---- 4-segment instance signals (H=2, CW=2)
  logic           a_aresetn;
  logic [D-1:0]   a_tdata;
  logic [U-1:0]   a_tuser;
  logic [K-1:0]   a_tkeep;
  logic           a_tlast, a_empty, a_rd_en;
  logic           a_fst_rdy, a_snd_rdy, a_out_rdy;
  logic [11:0]    a_vlan;
  logic           a_vlan_valid;
  logic [2*D-1:0] a_fst_tdata, a_snd_tdata;
  logic [2*U-1:0] a_fst_tuser, a_snd_tuser;
  logic [2*K-1:0] a_fst_tkeep, a_snd_tkeep;
  logic [1:0]     a_fst_tlast, a_snd_tlast, a_fst_nsegs, a_snd_nsegs;
  logic           a_fst_valid, a_snd_valid;
  logic [D-1:0]   a_out_tdata;
  logic [U-1:0]   a_out_tuser;
  logic [K-1:0]   a_out_tkeep;
  logic           a_out_tlast, a_out_valid;
  logic [31:0]    a_pkt_count, a_flush_count;

  // ---- 8-segment instance signals (H=4, CW=3)
  logic           b_aresetn;
  logic [D-1:0]   b_tdata;
  logic [U-1:0]   b_tuser;
  logic [K-1:0]   b_tkeep;
  logic           b_tlast, b_empty, b_rd_en;
  logic [11:0]    b_vlan;
  logic           b_vlan_valid;
  logic [4*D-1:0] b_fst_tdata, b_snd_tdata;
  logic [4*U-1:0] b_fst_tuser, b_snd_tuser;
  logic [4*K-1:0] b_fst_tkeep, b_snd_tkeep;
  logic [3:0]     b_fst_tlast, b_snd_tlast;
  logic [2:0]     b_fst_nsegs, b_snd_nsegs;
  logic           b_fst_valid, b_snd_valid;
  logic [D-1:0]   b_out_tdata;
  logic [U-1:0]   b_out_tuser;
  logic [K-1:0]   b_out_tkeep;
  logic           b_out_tlast, b_out_valid;
  logic [31:0]    b_pkt_count, b_flush_count;

  depar_seg_gather #(.C_NUM_SEGS(4)) u_dut (
    .clk(clk), .aresetn(a_aresetn),
    .pkt_fifo_tdata(a_tdata), .pkt_fifo_tuser(a_tuser), .pkt_fifo_tkeep(a_tkeep),
    .pkt_fifo_tlast(a_tlast), .pkt_fifo_empty(a_empty), .pkt_fifo_rd_en(a_rd_en),
    .fst_half_fifo_ready(a_fst_rdy), .snd_half_fifo_ready(a_snd_rdy),
    .output_fifo_ready(a_out_rdy),
    .vlan(a_vlan), .vlan_valid(a_vlan_valid),
    .fst_half_tdata(a_fst_tdata), .fst_half_tuser(a_fst_tuser), .fst_half_tkeep(a_fst_tkeep),
    .fst_half_tlast(a_fst_tlast), .fst_half_nsegs(a_fst_nsegs), .fst_half_valid(a_fst_valid),
    .snd_half_tdata(a_snd_tdata), .snd_half_tuser(a_snd_tuser), .snd_half_tkeep(a_snd_tkeep),
    .snd_half_tlast(a_snd_tlast), .snd_half_nsegs(a_snd_nsegs), .snd_half_valid(a_snd_valid),
    .output_fifo_tdata(a_out_tdata), .output_fifo_tuser(a_out_tuser),
    .output_fifo_tkeep(a_out_tkeep), .output_fifo_tlast(a_out_tlast),
    .output_fifo_valid(a_out_valid),
    .pkt_count(a_pkt_count), .flush_count(a_flush_count)
  );

  depar_seg_gather #(.C_NUM_SEGS(8)) u_dut8 (
    .clk(clk), .aresetn(b_aresetn),
    .pkt_fifo_tdata(b_tdata), .pkt_fifo_tuser(b_tuser), .pkt_fifo_tkeep(b_tkeep),
    .pkt_fifo_tlast(b_tlast), .pkt_fifo_empty(b_empty), .pkt_fifo_rd_en(b_rd_en),
    .fst_half_fifo_ready(1'b1), .snd_half_fifo_ready(1'b1), .output_fifo_ready(1'b1),
    .vlan(b_vlan), .vlan_valid(b_vlan_valid),
    .fst_half_tdata(b_fst_tdata), .fst_half_tuser(b_fst_tuser), .fst_half_tkeep(b_fst_tkeep),
    .fst_half_tlast(b_fst_tlast), .fst_half_nsegs(b_fst_nsegs), .fst_half_valid(b_fst_valid),
    .snd_half_tdata(b_snd_tdata), .snd_half_tuser(b_snd_tuser), .snd_half_tkeep(b_snd_tkeep),
    .snd_half_tlast(b_snd_tlast), .snd_half_nsegs(b_snd_nsegs), .snd_half_valid(b_snd_valid),
    .output_fifo_tdata(b_out_tdata), .output_fifo_tuser(b_out_tuser),
    .output_fifo_tkeep(b_out_tkeep), .output_fifo_tlast(b_out_tlast),
    .output_fifo_valid(b_out_valid),
    .pkt_count(b_pkt_count), .flush_count(b_flush_count)
  );

  // Beat n of packet pkt. Beat 0 carries VLAN {pkt[3:0], 8'h23} at bit 116.
  function automatic logic [D-1:0] beat_d(input logic [7:0] pkt, input logic [7:0] n);
    logic [D-1:0] d;
    d         = '0;
    d[31:0]   = {16'hBEEF, pkt, n};
    d[D-1 -: 8] = pkt ^ n;
    if (n == 8'd0) d[116 +: 12] = {pkt[3:0], 8'h23};
    return d;
  endfunction

  function automatic logic [U-1:0] beat_u(input logic [7:0] pkt, input logic [7:0] n);
    return {{(U-16){1'b0}}, n, pkt};
  endfunction

  function automatic logic [K-1:0] beat_k(input logic [7:0] pkt, input logic [7:0] n);
    return {pkt, n, 16'hFFFF};
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_drive(input logic [7:0] pkt, input logic [7:0] n, input logic last);
    a_tdata = beat_d(pkt, n);
    a_tuser = beat_u(pkt, n);
    a_tkeep = beat_k(pkt, n);
    a_tlast = last;
    a_empty = 1'b0;
  endtask

  task automatic a_idle();
    a_tdata = '0; a_tuser = '0; a_tkeep = '0; a_tlast = 1'b0; a_empty = 1'b1;
  endtask

  task automatic b_drive(input logic [7:0] pkt, input logic [7:0] n, input logic last);
    b_tdata = beat_d(pkt, n);
    b_tuser = beat_u(pkt, n);
    b_tkeep = beat_k(pkt, n);
    b_tlast = last;
    b_empty = 1'b0;
  endtask

  task automatic b_idle();
    b_tdata = '0; b_tuser = '0; b_tkeep = '0; b_tlast = 1'b0; b_empty = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p, f, j;
    logic popped, orr;

    a_aresetn = 1'b0; b_aresetn = 1'b0;
    a_idle(); b_idle();
    a_fst_rdy = 1'b1; a_snd_rdy = 1'b1; a_out_rdy = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_vlan",      a_vlan, 12'h0);
    check("rst_fst_valid", a_fst_valid, 1'b0);
    check("rst_fst_tdata", a_fst_tdata, '0);
    check("rst_out_tdata", a_out_tdata, '0);
    check("rst_pkt_count", a_pkt_count, 32'd0);
    check("rst_flush",     a_flush_count, 32'd0);
    check("rst_rd_en",     a_rd_en, 1'b0);
    check("rst_b_pkt",     b_pkt_count, 32'd0);
    a_aresetn = 1'b1; b_aresetn = 1'b1;

    // 1-beat packet
    @(negedge clk); a_drive(8'd1, 8'd0, 1'b1);
    #1 check("t1_rd_en", a_rd_en, 1'b1);
    @(negedge clk); a_idle();
    check("t1_vlan",       a_vlan, 12'h123);
    check("t1_vlan_valid", a_vlan_valid, 1'b1);
    check("t1_fst_valid",  a_fst_valid, 1'b1);
    check("t1_snd_valid",  a_snd_valid, 1'b1);
    check("t1_fst_nsegs",  a_fst_nsegs, 2'd1);
    check("t1_snd_nsegs",  a_snd_nsegs, 2'd0);
    check("t1_snd_tdata",  a_snd_tdata, '0);
    check("t1_snd_tkeep",  a_snd_tkeep, '0);
    check("t1_fst_slot0",  a_fst_tdata[0 +: D], beat_d(8'd1, 8'd0));
    check("t1_fst_slot1",  a_fst_tdata[D +: D], '0);
    check("t1_fst_user0",  a_fst_tuser[0 +: U], beat_u(8'd1, 8'd0));
    check("t1_fst_tlast",  a_fst_tlast, 2'b01);
    check("t1_pkt_count",  a_pkt_count, 32'd1);
    @(negedge clk);
    check("t1_fst_pulse",  a_fst_valid, 1'b0);
    check("t1_vlan_pulse", a_vlan_valid, 1'b0);

    // 7-beat packet, all readies high
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        j = k - 1;
        check("t2_vlan_v", a_vlan_valid, j == 0);
        check("t2_fst_v",  a_fst_valid, j == 1);
        check("t2_snd_v",  a_snd_valid, j == 3);
        check("t2_out_v",  a_out_valid, j >= 4);
        if (j == 1) begin
          check("t2_fst_nsegs", a_fst_nsegs, 2'd2);
          check("t2_fst_slot0", a_fst_tdata[0 +: D], beat_d(8'd2, 8'd0));
          check("t2_fst_slot1", a_fst_tdata[D +: D], beat_d(8'd2, 8'd1));
        end
        if (j == 3) begin
          check("t2_snd_nsegs", a_snd_nsegs, 2'd2);
          check("t2_snd_slot0", a_snd_tdata[0 +: D], beat_d(8'd2, 8'd2));
          check("t2_snd_slot1", a_snd_tdata[D +: D], beat_d(8'd2, 8'd3));
        end
        if (j >= 4) begin
          check("t2_out_tdata", a_out_tdata, beat_d(8'd2, 8'(j)));
          check("t2_out_tkeep", a_out_tkeep, beat_k(8'd2, 8'(j)));
          check("t2_out_tlast", a_out_tlast, j == 6);
        end
      end
      if (k < 7) begin
        a_drive(8'd2, 8'(k), k == 6);
        #1 check("t2_rd_en", a_rd_en, 1'b1);
      end else begin
        a_idle();
      end
    end
    check("t2_flush_count", a_flush_count, 32'd3);
    check("t2_pkt_count",   a_pkt_count, 32'd2);
    @(negedge clk);
    check("t2_out_v_low",   a_out_valid, 1'b0);
    check("t2_out_zero",    a_out_tdata, '0);

    // 3-beat packet, second-half FIFO full for 5 cycles at the last beat
    @(negedge clk); a_drive(8'd3, 8'd0, 1'b0);
    @(negedge clk); a_drive(8'd3, 8'd1, 1'b0);
    @(negedge clk);
    check("t3_fst_v", a_fst_valid, 1'b1);
    a_drive(8'd3, 8'd2, 1'b1); a_snd_rdy = 1'b0;
    #1 check("t3_stall_rd", a_rd_en, 1'b0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      #1 check("t3_stall_rd", a_rd_en, 1'b0);
      check("t3_stall_snd_v", a_snd_valid, 1'b0);
    end
    @(negedge clk); a_snd_rdy = 1'b1;
    #1 check("t3_go_rd", a_rd_en, 1'b1);
    @(negedge clk); a_idle();
    check("t3_snd_v",     a_snd_valid, 1'b1);
    check("t3_snd_nsegs", a_snd_nsegs, 2'd1);
    check("t3_snd_slot0", a_snd_tdata[0 +: D], beat_d(8'd3, 8'd2));
    check("t3_snd_slot1", a_snd_tdata[D +: D], '0);
    check("t3_snd_tlast", a_snd_tlast, 2'b01);
    check("t3_pkt_count", a_pkt_count, 32'd3);

    // 8-beat packet with output_fifo_ready toggling every cycle
    p = 0; f = 0; popped = 1'b0; orr = 1'b0;
    for (int cyc = 0; cyc < 60 && f < 4; cyc++) begin
      @(negedge clk);
      if (popped) p++;
      if (a_out_valid) begin
        check("t4_beat", a_out_tdata, beat_d(8'd4, 8'(4 + f)));
        check("t4_tlast", a_out_tlast, f == 3);
        f++;
      end
      orr = !orr; a_out_rdy = orr;
      if (p < 8) a_drive(8'd4, 8'(p), p == 7);
      else       a_idle();
      #1 popped = a_rd_en;
    end
    a_idle(); a_out_rdy = 1'b1;
    check("t4_count", f, 4);
    @(negedge clk);
    check("t4_no_extra", a_out_valid, 1'b0);
    check("t4_flush_count", a_flush_count, 32'd7);
    check("t4_pkt_count", a_pkt_count, 32'd4);

    // Reset during FLUSH of a 6-beat packet
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); a_drive(8'd5, 8'(k), 1'b0);
    end
    @(negedge clk); a_drive(8'd5, 8'd5, 1'b1);
    check("t5_pre_out_v", a_out_valid, 1'b1);
    check("t5_pre_flush", a_flush_count, 32'd8);
    a_aresetn = 1'b0;
    @(negedge clk); a_idle();
    check("t5_out_v",     a_out_valid, 1'b0);
    check("t5_out_tdata", a_out_tdata, '0);
    check("t5_vlan",      a_vlan, 12'h0);
    check("t5_fst_tdata", a_fst_tdata, '0);
    check("t5_snd_tdata", a_snd_tdata, '0);
    check("t5_nsegs",     {a_fst_nsegs, a_snd_nsegs}, 4'd0);
    check("t5_pkt_count", a_pkt_count, 32'd0);
    check("t5_flush",     a_flush_count, 32'd0);
    a_aresetn = 1'b1;
    @(negedge clk); a_drive(8'd6, 8'd0, 1'b1);
    #1 check("t5_post_rd", a_rd_en, 1'b1);
    @(negedge clk); a_idle();
    check("t5_post_fst_v", a_fst_valid, 1'b1);
    check("t5_post_snd_v", a_snd_valid, 1'b1);
    check("t5_post_vlan",  a_vlan, 12'h623);
    check("t5_post_nsegs", a_fst_nsegs, 2'd1);
    check("t5_post_out_v", a_out_valid, 1'b0);
    check("t5_post_pkt",   a_pkt_count, 32'd1);

    // 8 segments: 10-beat packet then a 2-beat packet back to back
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k > 0) begin
        j = k - 1;
        check("t6_fst_v", b_fst_valid, (j == 3) || (j == 11));
        check("t6_snd_v", b_snd_valid, (j == 7) || (j == 11));
        check("t6_out_v", b_out_valid, (j == 8) || (j == 9));
        if (j == 3) begin
          check("t6_fst_nsegs", b_fst_nsegs, 3'd4);
          check("t6_fst_slot3", b_fst_tdata[3*D +: D], beat_d(8'd7, 8'd3));
        end
        if (j == 7) begin
          check("t6_snd_nsegs", b_snd_nsegs, 3'd4);
          check("t6_snd_slot0", b_snd_tdata[0 +: D], beat_d(8'd7, 8'd4));
          check("t6_snd_slot3", b_snd_tdata[3*D +: D], beat_d(8'd7, 8'd7));
        end
        if (j == 8 || j == 9) begin
          check("t6_out_tdata", b_out_tdata, beat_d(8'd7, 8'(j)));
          check("t6_out_tlast", b_out_tlast, j == 9);
        end
        if (j == 11) begin
          check("t6_p2_fst_nsegs", b_fst_nsegs, 3'd2);
          check("t6_p2_snd_nsegs", b_snd_nsegs, 3'd0);
          check("t6_p2_slot0",     b_fst_tdata[0 +: D], beat_d(8'd8, 8'd0));
          check("t6_p2_slot1",     b_fst_tdata[D +: D], beat_d(8'd8, 8'd1));
          check("t6_p2_slot2",     b_fst_tdata[2*D +: D], '0);
          check("t6_p2_slot3",     b_fst_tdata[3*D +: D], '0);
          check("t6_p2_tlast",     b_fst_tlast, 4'b0010);
          check("t6_p2_snd_zero",  b_snd_tdata == '0, 1'b1);
          check("t6_p2_vlan",      b_vlan, 12'h823);
        end
      end
      if (k < 10)      b_drive(8'd7, 8'(k), k == 9);
      else if (k < 12) b_drive(8'd8, 8'(k - 10), k == 11);
      else             b_idle();
      #1 if (k < 12) check("t6_rd_en", b_rd_en, 1'b1);
    end
    check("t6_flush_count", b_flush_count, 32'd2);
    check("t6_pkt_count",   b_pkt_count, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
